// File: rtl/ecm_dds.sv
// ecm_dds -- multi-channel direct digital synthesiser.
//
// Every valid Timing_ctrl sample makes one I/Q output sample four cycles
// later. The channel's stored mode picks what that sample holds: a quadrature
// tone from a phase accumulator and sine ROM, noise from a shared LFSR, or
// zero. There is no backpressure. A separate checker pulses
// Error_index_sequence when the channel index sequence is broken.
//
// Ports
//   Clk                  : clock, all logic on the rising edge
//   Rst                  : synchronous, active-low reset
//   Dds_control          : {valid, channel_index[CH_W], mode[2],
//                           phase_increment[PHASE_WIDTH], initial_phase[PHASE_WIDTH]}
//                          mode: 0=off, 1=tone, 2=noise, 3=off
//   Timing_ctrl          : {valid, last, data_index[CH_W]} sample strobe
//   Dds_ctrl             : {valid, last, data_index[CH_W]} of the produced sample
//   Dds_data             : {Q, I}, each DATA_WIDTH signed, I in the low half
//   Error_index_sequence : one-cycle pulse, the cycle after an out-of-order index
module ecm_dds #(
  parameter int NUM_CHANNELS   = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int CTRL_W = 3 + CH_W + 2 * PHASE_WIDTH,
  localparam int TIME_W = 2 + CH_W
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [CTRL_W-1:0]       Dds_control,
  input  logic [TIME_W-1:0]       Timing_ctrl,
  output logic [TIME_W-1:0]       Dds_ctrl,
  output logic [2*DATA_WIDTH-1:0] Dds_data,
  output logic                    Error_index_sequence
);

  localparam int LUT_DEPTH = 1 << LUT_ADDR_WIDTH;
  localparam logic [LUT_ADDR_WIDTH-1:0] QUARTER = LUT_ADDR_WIDTH'(LUT_DEPTH / 4);
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam real PI        = 3.14159265358979323846;
  localparam real AMPLITUDE = (2.0 ** (DATA_WIDTH - 1)) - 1.0;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_TONE  = 2'd1,
    MODE_NOISE = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  // Input field decode
  logic                   ctl_valid;
  logic [CH_W-1:0]        ctl_ch;
  logic [1:0]             ctl_mode;
  logic [PHASE_WIDTH-1:0] ctl_inc;
  logic [PHASE_WIDTH-1:0] ctl_init;
  logic                   tim_valid;
  logic                   tim_last;
  logic [CH_W-1:0]        tim_idx;

  assign ctl_valid = Dds_control[CTRL_W-1];
  assign ctl_ch    = Dds_control[CTRL_W-2 -: CH_W];
  assign ctl_mode  = Dds_control[2*PHASE_WIDTH +: 2];
  assign ctl_inc   = Dds_control[PHASE_WIDTH +: PHASE_WIDTH];
  assign ctl_init  = Dds_control[0 +: PHASE_WIDTH];
  assign tim_valid = Timing_ctrl[TIME_W-1];
  assign tim_last  = Timing_ctrl[TIME_W-2];
  assign tim_idx   = Timing_ctrl[CH_W-1:0];

  // Sine ROM. The cosine is read from the same table a quarter turn ahead.
  // The values are rounded to nearest, and their magnitude never goes over
  // 2^(DATA_WIDTH-1)-1.
  logic signed [DATA_WIDTH-1:0] sin_rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_sin_rom
    localparam real SCALED  = AMPLITUDE * $sin(2.0 * PI * k / LUT_DEPTH);
    localparam int  ROUNDED = (SCALED >= 0.0) ? $rtoi(SCALED + 0.5) : -$rtoi(0.5 - SCALED);
    assign sin_rom[k] = DATA_WIDTH'(ROUNDED);
  end

  // Per-channel state
  mode_t                  mode_mem [NUM_CHANNELS];
  logic [PHASE_WIDTH-1:0] inc_mem  [NUM_CHANNELS];
  logic [PHASE_WIDTH-1:0] acc_mem  [NUM_CHANNELS];

  // Pipeline registers
  logic                   s1_valid, s1_last, s1_wb;
  logic [CH_W-1:0]        s1_idx;
  mode_t                  s1_mode;
  logic [PHASE_WIDTH-1:0] s1_inc, s1_acc, s1_next_acc;

  logic                          s2_valid, s2_last;
  logic [CH_W-1:0]               s2_idx;
  mode_t                         s2_mode;
  logic [LUT_ADDR_WIDTH-1:0]     s2_addr, s2_cos_addr;
  logic signed [DATA_WIDTH-1:0]  s2_noise_i, s2_noise_q;

  logic                          s3_valid, s3_last;
  logic [CH_W-1:0]               s3_idx;
  logic signed [DATA_WIDTH-1:0]  s3_i, s3_q;

  logic [31:0]            lfsr, lfsr_next;
  logic [CH_W-1:0]        exp_idx;

  mode_t                  rd_mode;
  logic [PHASE_WIDTH-1:0] rd_inc, rd_acc;

  // The sample in stage 1 has not yet written back its advanced accumulator.
  // A same-channel sample one cycle behind it takes that value directly.
  // Samples two or more cycles behind see it in acc_mem.
  assign s1_next_acc = (s1_mode == MODE_TONE) ? s1_acc + s1_inc : s1_acc;

  always_comb begin
    rd_mode = mode_mem[tim_idx];
    rd_inc  = inc_mem[tim_idx];
    rd_acc  = acc_mem[tim_idx];
    if (s1_wb && (s1_idx == tim_idx)) begin
      rd_acc = s1_next_acc;
    end
  end

  assign lfsr_next   = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
  assign s2_cos_addr = s2_addr + QUARTER;

  // Channel state update. A control write to a channel is placed after the
  // write-back, so it wins when both land in the same cycle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        mode_mem[c] <= MODE_OFF;
        inc_mem[c]  <= '0;
        acc_mem[c]  <= '0;
      end
    end else begin
      if (s1_wb) begin
        acc_mem[s1_idx] <= s1_next_acc;
      end
      if (ctl_valid) begin
        mode_mem[ctl_ch] <= mode_t'(ctl_mode);
        inc_mem[ctl_ch]  <= ctl_inc;
        acc_mem[ctl_ch]  <= ctl_init;
      end
    end
  end

  // Stage 1: capture the sample together with the state it read. The sample
  // is dropped from write-back when a control write to its channel arrives in
  // the same cycle, because the freshly loaded initial phase must survive.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      s1_valid <= 1'b0;
      s1_wb    <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
      s1_mode  <= MODE_OFF;
      s1_inc   <= '0;
      s1_acc   <= '0;
    end else begin
      s1_valid <= tim_valid;
      s1_wb    <= tim_valid && !(ctl_valid && (ctl_ch == tim_idx));
      s1_last  <= tim_last;
      s1_idx   <= tim_idx;
      s1_mode  <= rd_mode;
      s1_inc   <= rd_inc;
      s1_acc   <= rd_acc;
    end
  end

  // Stage 2: latch the output phase and take noise from the shared LFSR.
  // I is taken before the advance and Q after it.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      s2_idx     <= '0;
      s2_mode    <= MODE_OFF;
      s2_addr    <= '0;
      s2_noise_i <= '0;
      s2_noise_q <= '0;
      lfsr       <= LFSR_SEED;
    end else begin
      s2_valid   <= s1_valid;
      s2_last    <= s1_last;
      s2_idx     <= s1_idx;
      s2_mode    <= s1_mode;
      s2_addr    <= s1_acc[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
      s2_noise_i <= lfsr[DATA_WIDTH-1:0];
      s2_noise_q <= lfsr_next[DATA_WIDTH-1:0];
      if (s1_valid && (s1_mode == MODE_NOISE)) begin
        lfsr <= lfsr_next;
      end
    end
  end

  // Stage 3: ROM read and selection of the source for this sample's mode
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      s3_idx   <= '0;
      s3_i     <= '0;
      s3_q     <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_last  <= s2_last;
      s3_idx   <= s2_idx;
      case (s2_mode)
        MODE_TONE: begin
          s3_i <= sin_rom[s2_cos_addr];
          s3_q <= sin_rom[s2_addr];
        end
        MODE_NOISE: begin
          s3_i <= s2_noise_i;
          s3_q <= s2_noise_q;
        end
        default: begin
          s3_i <= '0;
          s3_q <= '0;
        end
      endcase
    end
  end

  // Stage 4: output register. The data is forced to zero when no sample is valid.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      Dds_ctrl <= '0;
      Dds_data <= '0;
    end else begin
      Dds_ctrl <= {s3_valid, s3_last, s3_idx};
      Dds_data <= s3_valid ? {s3_q, s3_i} : '0;
    end
  end

  // Index sequence checker. It expects the next index, and expects 0 after a
  // last sample. After a mismatch it follows on from the index actually seen.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      exp_idx              <= '0;
      Error_index_sequence <= 1'b0;
    end else begin
      Error_index_sequence <= tim_valid && (tim_idx != exp_idx);
      if (tim_valid) begin
        exp_idx <= tim_last ? '0 : tim_idx + CH_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ecm_dds.sv
// tb_ecm_dds -- self-checking bench for ecm_dds.
//
// A behavioural model handles each sample in the order it arrives. It uses
// real-valued trigonometry and per-channel arrays, and it queues the expected
// output four cycles ahead. Table rows may pin exact I/Q values in place of
// the model's. The outputs are sampled 1 time unit after every rising edge.
module tb_ecm_dds;

  localparam int NCH    = 8;
  localparam int DW     = 16;
  localparam int PW     = 32;
  localparam int LAW    = 10;
  localparam int CW     = 3;
  localparam int CTRL_W = 3 + CW + 2 * PW;
  localparam int TIME_W = 2 + CW;
  localparam real PI    = 3.14159265358979323846;
  localparam real AMP   = 32767.0;
  localparam logic [31:0] INC_Q = 32'h4000_0000;

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic [CTRL_W-1:0] Dds_control = '0;
  logic [TIME_W-1:0] Timing_ctrl = '0;
  logic [TIME_W-1:0] Dds_ctrl;
  logic [2*DW-1:0]   Dds_data;
  logic              Error_index_sequence;

  ecm_dds #(
    .NUM_CHANNELS  (NCH),
    .DATA_WIDTH    (DW),
    .PHASE_WIDTH   (PW),
    .LUT_ADDR_WIDTH(LAW)
  ) dut (
    .Clk                 (Clk),
    .Rst                 (Rst),
    .Dds_control         (Dds_control),
    .Timing_ctrl         (Timing_ctrl),
    .Dds_ctrl            (Dds_ctrl),
    .Dds_data            (Dds_data),
    .Error_index_sequence(Error_index_sequence)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          c_v;
    int          c_ch;
    int          c_mode;
    logic [31:0] c_inc;
    logic [31:0] c_init;
    bit          t_v;
    bit          t_last;
    int          t_idx;
    bit          has_exp;
    int          e_i;
    int          e_q;
  } vec_t;

  typedef struct {
    int due;
    bit last;
    int idx;
    int i;
    int q;
  } out_t;

  vec_t        vecs[$];
  out_t        outq[$];
  int          m_mode[NCH];
  logic [31:0] m_inc[NCH];
  logic [31:0] m_acc[NCH];
  logic [31:0] m_lfsr;
  int          m_exp_idx;
  bit          exp_err;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          valid_seen = 0;
  int          err_seen = 0;

  function automatic vec_t mkVec(bit c_v, int c_ch, int c_mode, logic [31:0] c_inc,
                                 logic [31:0] c_init, bit t_v, bit t_last, int t_idx,
                                 bit has_exp, int e_i, int e_q);
    vec_t v;
    v.c_v = c_v; v.c_ch = c_ch; v.c_mode = c_mode; v.c_inc = c_inc; v.c_init = c_init;
    v.t_v = t_v; v.t_last = t_last; v.t_idx = t_idx;
    v.has_exp = has_exp; v.e_i = e_i; v.e_q = e_q;
    return v;
  endfunction

  function automatic vec_t idleVec();
    return mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t sampleVec(int idx, bit last, bit has_exp, int e_i, int e_q);
    return mkVec(0, 0, 0, 0, 0, 1, last, idx, has_exp, e_i, e_q);
  endfunction

  function automatic int rnd(real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  task automatic compare(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0;
      m_inc[c]  = '0;
      m_acc[c]  = '0;
    end
    m_lfsr    = 32'hACE1_0001;
    m_exp_idx = 0;
    outq.delete();
  endtask

  // Work out the expected result of one clock edge in plain arithmetic.
  // The sample uses the state from before this edge's control write.
  task automatic modelEdge(input bit rst_n, input vec_t v);
    out_t r;
    int   addr;
    real  ang;
    exp_err = 1'b0;
    if (!rst_n) begin
      modelReset();
    end else begin
      if (v.t_v) begin
        r.due  = cyc + 3;
        r.last = v.t_last;
        r.idx  = v.t_idx;
        r.i    = 0;
        r.q    = 0;
        if (m_mode[v.t_idx] == 1) begin
          addr = int'(m_acc[v.t_idx] >> (PW - LAW));
          ang  = 2.0 * PI * addr / 1024.0;
          r.i  = rnd(AMP * $cos(ang));
          r.q  = rnd(AMP * $sin(ang));
          m_acc[v.t_idx] = m_acc[v.t_idx] + m_inc[v.t_idx];
        end else if (m_mode[v.t_idx] == 2) begin
          r.i    = int'($signed(m_lfsr[DW-1:0]));
          m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
          r.q    = int'($signed(m_lfsr[DW-1:0]));
        end
        if (v.has_exp) begin
          r.i = v.e_i;
          r.q = v.e_q;
        end
        outq.push_back(r);
        exp_err   = (v.t_idx != m_exp_idx);
        m_exp_idx = v.t_last ? 0 : (v.t_idx + 1) % NCH;
      end
      if (v.c_v) begin
        m_mode[v.c_ch] = v.c_mode;
        m_inc[v.c_ch]  = v.c_inc;
        m_acc[v.c_ch]  = v.c_init;
      end
    end
  endtask

  task automatic checkOutput();
    bit   ev;
    out_t e;
    ev = (outq.size() > 0) && (outq[0].due == cyc);
    valid_seen += int'(Dds_ctrl[TIME_W-1]);
    err_seen   += int'(Error_index_sequence);
    compare("out_valid", int'(Dds_ctrl[TIME_W-1]), int'(ev));
    if (ev) begin
      e = outq.pop_front();
      compare("out_last", int'(Dds_ctrl[TIME_W-2]), int'(e.last));
      compare("out_index", int'(Dds_ctrl[CW-1:0]), e.idx);
      compare("out_i", int'($signed(Dds_data[DW-1:0])), e.i);
      compare("out_q", int'($signed(Dds_data[2*DW-1:DW])), e.q);
    end else begin
      compare("idle_data_zero", int'(Dds_data != '0), 0);
    end
    compare("index_error", int'(Error_index_sequence), int'(exp_err));
  endtask

  // Drive one cycle of inputs, let the edge happen, then check the outputs.
  task automatic applyStimulus(input bit rst_n, input vec_t v);
    Rst         = rst_n;
    Dds_control = {v.c_v, CW'(v.c_ch), 2'(v.c_mode), v.c_inc, v.c_init};
    Timing_ctrl = {v.t_v, v.t_last, CW'(v.t_idx)};
    @(posedge Clk);
    cyc++;
    modelEdge(rst_n, v);
    #1;
    checkOutput();
  endtask

  initial begin
    int v0, e0;

    // Directed vectors: expected I/Q are exact constants
    // ch3 tone, quarter-turn steps, widely spaced samples
    vecs.push_back(mkVec(1, 3, 1, INC_Q, 32'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(sampleVec(3, 0, 1, 32767, 0));
    vecs.push_back(idleVec());
    vecs.push_back(sampleVec(3, 0, 1, 0, 32767));
    vecs.push_back(idleVec());
    vecs.push_back(sampleVec(3, 0, 1, -32767, 0));
    vecs.push_back(idleVec());
    vecs.push_back(sampleVec(3, 0, 1, 0, -32767));
    // ch0 tone, back-to-back samples with no gap
    vecs.push_back(mkVec(1, 0, 1, INC_Q, 32'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(sampleVec(0, 0, 1, 32767, 0));
    vecs.push_back(sampleVec(0, 0, 1, 0, 32767));
    vecs.push_back(sampleVec(0, 0, 1, -32767, 0));
    vecs.push_back(sampleVec(0, 0, 1, 0, -32767));
    // ch1 tone, the accumulator wraps
    vecs.push_back(mkVec(1, 1, 1, 32'hC000_0000, 32'h8000_0000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(sampleVec(1, 0, 1, -32767, 0));
    vecs.push_back(idleVec());
    vecs.push_back(sampleVec(1, 0, 1, 0, 32767));
    vecs.push_back(sampleVec(1, 0, 1, 32767, 0));
    // ch4: a write in the same cycle as a sample; the sample sees the old state, then the write wins
    vecs.push_back(mkVec(1, 4, 1, INC_Q, 32'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(sampleVec(4, 0, 1, 32767, 0));
    vecs.push_back(mkVec(1, 4, 1, INC_Q, 32'h8000_0000, 1, 0, 4, 1, 0, 32767));
    vecs.push_back(sampleVec(4, 0, 1, -32767, 0));
    for (int k = 0; k < 6; k++) vecs.push_back(idleVec());

    modelReset();
    for (int k = 0; k < 3; k++) applyStimulus(0, idleVec());

    for (int k = 0; k < vecs.size(); k++) applyStimulus(1, vecs[k]);

    // All channels off after reset: a full sweep, then an out-of-order index
    for (int k = 0; k < 2; k++) applyStimulus(0, idleVec());
    v0 = valid_seen;
    e0 = err_seen;
    for (int c = 0; c < NCH; c++) applyStimulus(1, sampleVec(c, c == NCH - 1, 1, 0, 0));
    applyStimulus(1, sampleVec(0, 0, 1, 0, 0));
    applyStimulus(1, sampleVec(2, 0, 1, 0, 0));
    for (int k = 0; k < 5; k++) applyStimulus(1, idleVec());
    compare("sweep_valid_count", valid_seen - v0, NCH + 2);
    compare("sweep_error_pulses", err_seen - e0, 1);

    // ch2 noise: reset drops the samples still in flight, and the mode returns to off
    applyStimulus(1, mkVec(1, 2, 2, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) applyStimulus(1, sampleVec(2, 0, 0, 0, 0));
    v0 = valid_seen;
    for (int k = 0; k < 3; k++) applyStimulus(0, idleVec());
    applyStimulus(1, sampleVec(2, 0, 1, 0, 0));
    for (int k = 0; k < 5; k++) applyStimulus(1, idleVec());
    compare("post_reset_valid_count", valid_seen - v0, 1);

    // Randomised traffic. Indices are weighted towards two channels so that
    // same-channel samples arrive back to back.
    for (int k = 0; k < 3000; k++) begin
      vec_t v;
      int   idx;
      idx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NCH - 1))
                                        : int'($urandom_range(0, 1));
      v = mkVec($urandom_range(0, 4) == 0, int'($urandom_range(0, NCH - 1)),
                int'($urandom_range(0, 3)), $urandom, $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, idx, 0, 0, 0);
      applyStimulus($urandom_range(0, 799) != 0, v);
    end
    for (int k = 0; k < 6; k++) applyStimulus(1, idleVec());
    compare("pending_outputs_left", outq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ecm_dds.md
ECM_DDS -- requirements
Module: ecm_dds

Interface
REQ-001 Parameter NUM_CHANNELS, default ecm_num_channels: number of channels; power of two.
REQ-002 Parameter DATA_WIDTH, default ecm_dds_data_width: signed I/Q output width.
REQ-003 Parameter PHASE_WIDTH, default 32: per-channel phase accumulator and increment width.
REQ-004 Parameter LUT_ADDR_WIDTH, default 10: sine/cosine table address width (1024 entries).
REQ-005 Clk  input  1: clock; all logic rising-edge.
REQ-006 Rst  input  1: reset, synchronous, active-low.
REQ-007 Dds_control  input  struct: valid, channel_index, mode (2 bits: 0=off, 1=tone, 2=noise), phase_increment (PHASE_WIDTH), initial_phase (PHASE_WIDTH).
REQ-008 Timing_ctrl  input  channelizer_control_t: valid/last/data_index sample strobe that also feeds the DRFM path.
REQ-009 Dds_ctrl  output  channelizer_control_t: valid/last/data_index of the produced sample.
REQ-010 Dds_data  output  2 x DATA_WIDTH signed: [0]=I, [1]=Q.
REQ-011 Error_index_sequence  output  1: one-cycle pulse on an out-of-order timing index.

Function
REQ-012 Per channel, the block SHALL store mode, phase_increment and phase accumulator in NUM_CHANNELS-deep registers/RAM.
REQ-013 A Dds_control write SHALL load mode and phase_increment, and set the accumulator to initial_phase, for channel_index; it takes effect for any Timing_ctrl sample entering stage 1 on the following cycle or later.
REQ-014 Each valid Timing_ctrl sample SHALL produce exactly one Dds_ctrl.valid, exactly 4 cycles later, with last and data_index copied unchanged.
REQ-015 The block SHALL not exert backpressure; the gap between Timing_ctrl samples is 0..N cycles.
REQ-016 Pipeline: S1 read channel state; S2 compute output phase, write back accumulator; S3 LUT read; S4 output register.
REQ-017 Mode tone: output phase = current accumulator; I = LUT_cos[phase[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH]], Q = LUT_sin[same]; accumulator += phase_increment modulo 2^PHASE_WIDTH (wraps silently).
REQ-018 LUT entries SHALL equal round((2^(DATA_WIDTH-1)-1) * cos/sin(2*pi*k/2^LUT_ADDR_WIDTH)); they never reach -2^(DATA_WIDTH-1).
REQ-019 Mode noise: I and Q SHALL be the low DATA_WIDTH bits of a shared 32-bit Galois LFSR (taps 32,22,2,1, seed 0xACE1_0001), advanced once per valid sample in this mode; I is taken before the advance and Q after it; accumulator unchanged.
REQ-020 Mode off or mode 3: I = Q = 0; accumulator unchanged; valid still emitted.
REQ-021 Same-channel samples on back-to-back or 1-gap cycles SHALL see the updated accumulator (S2->S1 forwarding); results SHALL equal those of widely spaced samples.
REQ-022 A Dds_control write and a sample for the same channel in the same cycle: the sample uses the old state; the write wins the accumulator write-back.
REQ-023 Error_index_sequence SHALL pulse when a valid sample's data_index != (previous valid index + 1) mod NUM_CHANNELS; after a sample with last=1, or the first sample after reset, the expected index is 0.
REQ-024 Dds_ctrl.data_index and last SHALL be don't-care when valid=0; Dds_data SHALL be held at 0 when valid=0.

Reset
REQ-025 While Rst=0: Dds_ctrl.valid=0, Dds_data=0, Error_index_sequence=0, all in-flight pipeline valids cleared, LFSR = seed, sequence checker expects index 0.
REQ-026 Channel mode SHALL reset to off; increments and accumulators reset to 0.
REQ-027 Reset asserted mid-stream SHALL drop all in-flight samples; the first output after release SHALL correspond to a sample accepted after release.

Verification
REQ-028 Ch 3: tone, inc=2^30, init=0; samples idx 3 x4 -> I/Q = (32767,0),(0,32767),(-32767,0),(0,-32767) at DATA_WIDTH=16, each 4 cycles after its input.
REQ-029 Ch 0: tone, inc=2^30; back-to-back idx 0 samples with 0 gap -> same sequence as REQ-028 (forwarding check).
REQ-030 Ch 1: tone, inc=0xC000_0000, init=0x8000_0000; 3 samples -> accumulator wraps; phases 0x8000_0000, 0x4000_0000, 0x0 -> I = -32767, 0, 32767.
REQ-031 All channels off; full round-robin sweep 0..N-1 with last on N-1 -> N valids, all data 0, no error; then idx 0,2 -> Error_index_sequence pulses once, aligned with input cycle + 1.
REQ-032 Ch 2 noise; 8 samples -> I/Q match reference LFSR model; Rst=0 after sample 5 -> outputs 6-8 never appear; after release, channel 2 outputs 0 (mode off).
